// File: rtl/systolic_matmul_nxn.sv
//------------------------------------------------------------------------------
// Module  : systolic_matmul_nxn
// Brief   : N x N output-stationary signed matmul with self skewing, flush and
//           row drain. Optional macro SYSTOLIC_SAT_EN: saturating accumulate.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module systolic_matmul_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N*DATA_W-1:0] a_col_i,
  input  logic [N*DATA_W-1:0] b_row_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [N*ACC_W-1:0]  out_row_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                sat_flag_o
);

  localparam int CNT_W = $clog2(2*N);
  localparam int ROW_W = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;

  logic w_accept, w_flush, w_adv, w_first;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          cnt_d   = CNT_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (cnt_q == CNT_W'(N-1)) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // 2N-1 zero-injecting advances push the last products through the skew
        if (cnt_q == CNT_W'(2*N-2)) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (row_q == ROW_W'(N-1)) begin
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  assign w_accept   = in_valid_i & in_ready_o;
  assign w_flush    = (state_q == S_FLUSH);
  assign w_adv      = w_accept | w_flush;
  assign w_first    = w_accept & (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign out_last_o = (state_q == S_DRAIN) && (row_q == ROW_W'(N-1));

  logic [N*DATA_W-1:0] w_a_edge, w_b_edge;

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] w_a_in, w_b_in;
    assign w_a_in = w_flush ? '0 : a_col_i[i*DATA_W +: DATA_W];
    assign w_b_in = w_flush ? '0 : b_row_i[i*DATA_W +: DATA_W];

    if (i == 0) begin : g_pass
      assign w_a_edge[i*DATA_W +: DATA_W] = w_a_in;
      assign w_b_edge[i*DATA_W +: DATA_W] = w_b_in;
    end else begin : g_dly
      logic [DATA_W-1:0] a_sr_q [i];
      logic [DATA_W-1:0] b_sr_q [i];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int d = 0; d < i; d++) begin
            a_sr_q[d] <= '0;
            b_sr_q[d] <= '0;
          end
        end else if (clear_i) begin
          for (int d = 0; d < i; d++) begin
            a_sr_q[d] <= '0;
            b_sr_q[d] <= '0;
          end
        end else if (w_adv) begin
          a_sr_q[0] <= w_a_in;
          b_sr_q[0] <= w_b_in;
          for (int d = 1; d < i; d++) begin
            a_sr_q[d] <= a_sr_q[d-1];
            b_sr_q[d] <= b_sr_q[d-1];
          end
        end
      end
      assign w_a_edge[i*DATA_W +: DATA_W] = a_sr_q[i-1];
      assign w_b_edge[i*DATA_W +: DATA_W] = b_sr_q[i-1];
    end
  end

  // Forwarding registers exist only where a neighbour consumes them
  logic [N*(N-1)*DATA_W-1:0] w_a_pe;
  logic [(N-1)*N*DATA_W-1:0] w_b_pe;
  logic [N*N*ACC_W-1:0]      w_acc;
`ifdef SYSTOLIC_SAT_EN
  logic [N*N-1:0]            w_sat;
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0]          w_a_in, w_b_in;
      logic signed [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
      logic signed [ACC_W-1:0]    w_prod_ext, w_base, acc_d, acc_q;

      if (j == 0) begin : g_a_edge
        assign w_a_in = w_a_edge[i*DATA_W +: DATA_W];
      end else begin : g_a_nbr
        assign w_a_in = w_a_pe[(i*(N-1)+j-1)*DATA_W +: DATA_W];
      end
      if (i == 0) begin : g_b_edge
        assign w_b_in = w_b_edge[j*DATA_W +: DATA_W];
      end else begin : g_b_nbr
        assign w_b_in = w_b_pe[((i-1)*N+j)*DATA_W +: DATA_W];
      end

      assign w_a_ext    = (2*DATA_W)'($signed(w_a_in));
      assign w_b_ext    = (2*DATA_W)'($signed(w_b_in));
      assign w_prod     = w_a_ext * w_b_ext;
      assign w_prod_ext = ACC_W'(w_prod);
      // The first beat of a job restarts accumulation with its own product
      assign w_base     = w_first ? '0 : acc_q;

`ifdef SYSTOLIC_SAT_EN
      logic signed [ACC_W:0] w_sum;
      logic                  w_ovf;
      assign w_sum = {w_base[ACC_W-1], w_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
      assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      assign acc_d = !w_ovf       ? w_sum[ACC_W-1:0] :
                     w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
      assign w_sat[i*N+j] = w_adv & w_ovf;
`else
      assign acc_d = w_base + w_prod_ext;
`endif

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          acc_q <= '0;
        end else if (clear_i) begin
          acc_q <= '0;
        end else if (w_adv) begin
          acc_q <= acc_d;
        end
      end
      assign w_acc[(i*N+j)*ACC_W +: ACC_W] = acc_q;

      if (j < N-1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni)      a_q <= '0;
          else if (clear_i) a_q <= '0;
          else if (w_adv)   a_q <= w_a_in;
        end
        assign w_a_pe[(i*(N-1)+j)*DATA_W +: DATA_W] = a_q;
      end
      if (i < N-1) begin : g_b_fwd
        logic [DATA_W-1:0] b_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni)      b_q <= '0;
          else if (clear_i) b_q <= '0;
          else if (w_adv)   b_q <= w_b_in;
        end
        assign w_b_pe[(i*N+j)*DATA_W +: DATA_W] = b_q;
      end
    end
  end

  always_comb begin
    out_row_o = '0;
    if (state_q == S_DRAIN) begin
      for (int r = 0; r < N; r++) begin
        if (row_q == ROW_W'(r)) out_row_o = w_acc[r*N*ACC_W +: N*ACC_W];
      end
    end
  end

`ifdef SYSTOLIC_SAT_EN
  logic sat_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      sat_q <= 1'b0;
    else if (clear_i) sat_q <= 1'b0;
    else              sat_q <= (sat_q & ~w_first) | (|w_sat);
  end
  assign sat_flag_o = sat_q;
`else
  assign sat_flag_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_matmul_nxn.sv
//------------------------------------------------------------------------------
// Module  : tb_systolic_matmul_nxn
// Brief   : Scoreboard bench: 4x4 engines at ACC_W=20 and ACC_W=16.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_matmul_nxn;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clr_a, iv_a, ir_a, ov_a, ordy_a, ol_a, busy_a, sat_a;
  logic [N*DW-1:0] acol_a, brow_a;
  logic [N*AW-1:0] orow_a;
  logic clr_b, iv_b, ir_b, ov_b, ordy_b, ol_b, busy_b, sat_b;
  logic [N*DW-1:0] acol_b, brow_b;
  logic [N*BW-1:0] orow_b;

  systolic_matmul_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_a), .in_valid_i(iv_a), .in_ready_o(ir_a),
    .a_col_i(acol_a), .b_row_i(brow_a), .out_valid_o(ov_a), .out_ready_i(ordy_a),
    .out_row_o(orow_a), .out_last_o(ol_a), .busy_o(busy_a), .sat_flag_o(sat_a));

  systolic_matmul_nxn #(.N(N), .DATA_W(DW), .ACC_W(BW)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr_b), .in_valid_i(iv_b), .in_ready_o(ir_b),
    .a_col_i(acol_b), .b_row_i(brow_b), .out_valid_o(ov_b), .out_ready_i(ordy_b),
    .out_row_o(orow_b), .out_last_o(ol_b), .busy_o(busy_b), .sat_flag_o(sat_b));

  int checks = 0;
  int errors = 0;
  int mA [N][N];
  int mB [N][N];
  logic [N*AW:0] q_a [$];
  logic [N*BW:0] q_b [$];
  logic [N*AW:0] e_a;
  logic [N*BW:0] e_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] row_a(input int v0, input int v1, input int v2, input int v3);
    return {AW'(v3), AW'(v2), AW'(v1), AW'(v0)};
  endfunction

  function automatic logic [N*BW-1:0] row_b(input int v);
    return {BW'(v), BW'(v), BW'(v), BW'(v)};
  endfunction

  task automatic push_a(input logic [N*AW-1:0] r0, input logic [N*AW-1:0] r1,
                        input logic [N*AW-1:0] r2, input logic [N*AW-1:0] r3);
    q_a.push_back({1'b0, r0});
    q_a.push_back({1'b0, r1});
    q_a.push_back({1'b0, r2});
    q_a.push_back({1'b1, r3});
  endtask

  task automatic fill(input int va, input int vb);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mA[i][j] = va;
        mB[i][j] = vb;
      end
  endtask

  task automatic set_2x2();
    fill(0, 0);
    mA[0][0] = 1; mA[0][1] = 2; mA[1][0] = 3; mA[1][1] = 4;
    mB[0][0] = 5; mB[0][1] = 6; mB[1][0] = 7; mB[1][1] = 8;
  endtask

  task automatic wait_ready(input int sel);
    int w;
    w = 0;
    @(negedge clk);
    while (!((sel == 0) ? ir_a : ir_b) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_job(input int sel, input int nbeats, input int stall_after, input int stall_cyc);
    logic [N*DW-1:0] ac, bc;
    for (int k = 0; k < nbeats; k++) begin
      for (int i = 0; i < N; i++) begin
        ac[i*DW +: DW] = DW'(mA[i][k]);
        bc[i*DW +: DW] = DW'(mB[k][i]);
      end
      if (sel == 0) begin acol_a = ac; brow_a = bc; iv_a = 1'b1; end
      else          begin acol_b = ac; brow_b = bc; iv_b = 1'b1; end
      wait_ready(sel);
      @(posedge clk); #1;
      if (k == stall_after) begin
        iv_a = 1'b0; iv_b = 1'b0;
        repeat (stall_cyc) begin @(posedge clk); #1; end
      end
    end
    iv_a = 1'b0; iv_b = 1'b0;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d rows pending expected 0", q_a.size() + q_b.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov_a && ordy_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_a_unexpected_row: got %0h expected none", orow_a);
      end else begin
        e_a = q_a.pop_front();
        check("dut_a_row", orow_a, e_a[N*AW-1:0]);
        check("dut_a_last", ol_a, e_a[N*AW]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_b && ordy_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_b_unexpected_row: got %0h expected none", orow_b);
      end else begin
        e_b = q_b.pop_front();
        check("dut_b_row", orow_b, e_b[N*BW-1:0]);
        check("dut_b_last", ol_b, e_b[N*BW]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, w, nv;
    rst_n = 1'b0;
    clr_a = 1'b0; iv_a = 1'b0; acol_a = '0; brow_a = '0; ordy_a = 1'b1;
    clr_b = 1'b0; iv_b = 1'b0; acol_b = '0; brow_b = '0; ordy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", ir_a, 1'b1);
    check("rst_out_valid", ov_a, 1'b0);
    check("rst_out_last", ol_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_sat", sat_a, 1'b0);
    check("rst_out_row", orow_a, '0);
    check("rst_b_busy", busy_b, 1'b0);
    @(posedge clk); #1;

    // 2x2 operands embedded in the 4x4 array; latency 2N-1 = 7
    set_2x2();
    push_a(row_a(19, 22, 0, 0), row_a(43, 50, 0, 0), row_a(0, 0, 0, 0), row_a(0, 0, 0, 0));
    send_job(0, N, -1, 0);
    lat = 0;
    @(negedge clk);
    while (!ov_a && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 7);
    wait_empty();

    // identity A, B[i][j] = 4i+j-8, with a 3-cycle stall after beat 1
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mA[i][j] = (i == j) ? 1 : 0;
        mB[i][j] = i*4 + j - 8;
      end
    push_a(row_a(-8, -7, -6, -5), row_a(-4, -3, -2, -1), row_a(0, 1, 2, 3), row_a(4, 5, 6, 7));
    send_job(0, N, 0, 3);
    wait_empty();

    fill(-128, -128);
    push_a(row_a(65536, 65536, 65536, 65536), row_a(65536, 65536, 65536, 65536),
           row_a(65536, 65536, 65536, 65536), row_a(65536, 65536, 65536, 65536));
    send_job(0, N, -1, 0);
    wait_empty();
    check("sat_a_wide_acc", sat_a, 1'b0);

    // back-pressure on row 1
    fill(127, 127);
    push_a(row_a(64516, 64516, 64516, 64516), row_a(64516, 64516, 64516, 64516),
           row_a(64516, 64516, 64516, 64516), row_a(64516, 64516, 64516, 64516));
    send_job(0, N, -1, 0);
    w = 0;
    @(negedge clk);
    while (!ov_a && w < 100) begin @(negedge clk); w++; end
    check("bp_row0_seen", ov_a, 1'b1);
    @(posedge clk); #1 ordy_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid_held", ov_a, 1'b1);
      check("bp_row_stable", orow_a, row_a(64516, 64516, 64516, 64516));
      check("bp_in_ready_low", ir_a, 1'b0);
      @(posedge clk); #1;
    end
    ordy_a = 1'b1;
    w = 0;
    @(negedge clk);
    while (!(ov_a && ol_a) && w < 50) begin @(negedge clk); w++; end
    check("bp_last_seen", ol_a, 1'b1);
    check("bp_in_ready_at_last", ir_a, 1'b0);
    @(negedge clk);
    check("bp_in_ready_after", ir_a, 1'b1);
    check("bp_valid_after", ov_a, 1'b0);
    wait_empty();

    // 16-bit accumulator: 4*16129 = 64516 wraps to -1020 or saturates
    fill(127, 127);
`ifdef SYSTOLIC_SAT_EN
    for (int r = 0; r < N; r++) q_b.push_back({(r == N-1), row_b(32767)});
`else
    for (int r = 0; r < N; r++) q_b.push_back({(r == N-1), row_b(-1020)});
`endif
    send_job(1, N, -1, 0);
    wait_empty();
`ifdef SYSTOLIC_SAT_EN
    check("sat_b_set", sat_b, 1'b1);
`else
    check("sat_b_set", sat_b, 1'b0);
`endif
    clr_b = 1'b1;
    @(posedge clk); #1 clr_b = 1'b0;
    @(negedge clk);
    check("sat_b_cleared", sat_b, 1'b0);
    @(posedge clk); #1;

    // abort during FLUSH
    set_2x2();
    send_job(0, N, -1, 0);
    @(posedge clk); #1 clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    @(negedge clk);
    check("clr_busy", busy_a, 1'b0);
    check("clr_in_ready", ir_a, 1'b1);
    check("clr_out_valid", ov_a, 1'b0);
    nv = 0;
    repeat (12) begin @(negedge clk); if (ov_a) nv++; end
    check("clr_no_output", nv, 0);
    @(posedge clk); #1;
    push_a(row_a(19, 22, 0, 0), row_a(43, 50, 0, 0), row_a(0, 0, 0, 0), row_a(0, 0, 0, 0));
    send_job(0, N, -1, 0);
    wait_empty();

    // asynchronous reset mid-LOAD
    set_2x2();
    send_job(0, 2, -1, 0);
    @(negedge clk);
    check("load_busy", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", ir_a, 1'b1);
    check("arst_busy", busy_a, 1'b0);
    check("arst_out_valid", ov_a, 1'b0);
    check("arst_out_row", orow_a, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_a(row_a(19, 22, 0, 0), row_a(43, 50, 0, 0), row_a(0, 0, 0, 0), row_a(0, 0, 0, 0));
    send_job(0, N, -1, 0);
    wait_empty();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_matmul_nxn.md
Name: systolic_matmul_nxn

Overview:
- Parametrised N x N output-stationary signed integer matrix-multiply engine.
- Computes C = A x B for N x N operands.
- Operands stream in one k-slice per beat: column k of A with row k of B.
- Block performs its own input skewing, flush and result drain over valid/ready handshakes, so upstream logic needs no systolic timing knowledge.

Parameters:
- N, 4, array dimension (rows = cols = k-depth); legal range 2..16.
- DATA_W, 8, signed operand width.
- ACC_W, 20, signed accumulator/result width; default ≥ 2*DATA_W + clog2(N).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: returns FSM to IDLE, zeroes accumulators and skew registers; priority over all other inputs.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid & in_ready.
- a_col  in  N*DATA_W  column k of A; lane i (bits i*DATA_W +: DATA_W) = A[i][k].
- b_row  in  N*DATA_W  row k of B; lane j = B[k][j].
- out_valid  out  1  result row valid.
- out_ready  in  1  result row consumed when out_valid & out_ready.
- out_row  out  N*ACC_W  row r of C; lane j = C[r][j].
- out_last  out  1  high with the final row (r = N-1).
- busy  out  1  high in LOAD, FLUSH, DRAIN.
- sat_flag  out  1  sticky saturation indicator; see Optional Feature.

Behaviour:

Reset:
- FSM = IDLE; all accumulators, skew and pipeline registers = 0.
- Outputs: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, sat_flag = 0, out_row = 0.

Datapath:
- Lane i of A is delayed i advance-cycles; lane j of B is delayed j advance-cycles.
- PE(i,j) registers a/b to its right/down neighbour and accumulates acc += a*b.
- Product is a full 2*DATA_W signed multiply, sign-extended to ACC_W; two's-complement wrap unless SYSTOLIC_SAT_EN is defined.
- The array advances only on an "advance" cycle: an accepted input beat in IDLE/LOAD, or every cycle in FLUSH. Otherwise all PE and skew registers hold.
- During FLUSH, zeros are injected at all array edges.

FSM:
- IDLE:
  - in_ready = 1.
  - First accepted beat zeroes all accumulators in the same cycle it is applied (that beat's products are the first term), sets beat counter = 1, and moves to LOAD. If N beats complete, go to FLUSH.
- LOAD:
  - in_ready = 1.
  - Each accepted beat increments the counter; in_valid low stalls the whole array.
  - On the Nth accepted beat, go to FLUSH.
- FLUSH:
  - in_ready = 0.
  - Exactly 2N-1 advance cycles, then go to DRAIN.
  - out_valid rises exactly 2N-1 cycles after the edge that accepted the last input beat.
- DRAIN:
  - out_valid = 1; out_row = row r, starting at r = 0.
  - r increments on each handshake; out_row stays stable while out_ready = 0.
  - Handshake with r = N-1 (out_last = 1) returns to IDLE; in_ready becomes 1 in the following cycle.
  - No input is accepted during DRAIN.

Boundary conditions:
- clear in any state: next cycle is IDLE, outputs at reset values except sat_flag, which is also cleared.
- rst_n low mid-operation: immediate return to reset state.
- in_valid held low indefinitely in LOAD: no timeout; state is retained.

Optional Feature:
- Macro: SYSTOLIC_SAT_EN.
- Defined:
  - Each accumulate saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - Any saturation event sets sat_flag, which stays high until clear or reset. The flag is also cleared at the first beat of a new job.
- Undefined:
  - Accumulators wrap modulo 2^ACC_W.
  - sat_flag is tied to 0; no saturation logic is synthesised.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], continuous beats, out_ready=1:
  - Rows [19,22] then [43,50]; out_last on the second row.
  - out_valid rises 3 cycles after the last accept.
- N=4, A=identity, B[i][j]=i*4+j-8, with in_valid deasserted 3 cycles between beats 1 and 2:
  - C == B row for row; stalls do not change results.
- N=4, all A=-128, all B=-128 (ACC_W=20): every C entry = 65536.
- N=4, A=all 127, B=all 127, ACC_W=16:
  - Without macro: every entry = 64516 mod 2^16 = -1020 signed.
  - With SYSTOLIC_SAT_EN: every entry = 32767 and sat_flag = 1.
- Back-pressure: hold out_ready=0 for 5 cycles during DRAIN row 1:
  - out_row stable and out_valid held.
  - in_ready stays 0 until the cycle after the row-3 handshake.
- Abort:
  - Pulse clear in FLUSH → IDLE next cycle, no out_valid.
  - Then run the 2x2 case again → correct [19,22],[43,50].
  - Repeat with rst_n asserted mid-LOAD → outputs at reset values immediately.
